// File: rtl/cva6_ras_circ_pkg.sv
// Shared types for the circular return-address stack.
// Core configuration subset consumed by the RAS.
package cva6_ras_circ_pkg;

  typedef struct packed {
    int unsigned RASDepth;
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    RASDepth: 32'd2,
    VLEN:     32'd64
  };

endpackage

// File: rtl/cva6_ras_circ.sv
// Circular return-address stack: push on call, pop on return.
// Optional perf counters under macro RAS_PERF_CNT_EN.
module cva6_ras_circ
  import cva6_ras_circ_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned DEPTH = CVA6Cfg.RASDepth,
  parameter int unsigned VLEN  = CVA6Cfg.VLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic [VLEN:0]   data_o,
`ifdef RAS_PERF_CNT_EN
  output logic [31:0]     ovf_cnt_o,
  output logic [31:0]     udf_cnt_o,
`endif
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] TP_MAX = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] ra;
  } ras_t;

  logic [VLEN-1:0] ra_q    [DEPTH];
  logic            valid_q [DEPTH];
  logic [PW-1:0]   tp_q;
  logic [OW-1:0]   occ_q;
  logic            ovf_q;
  logic            udf_q;
  logic [PW-1:0]   tp_inc;
  logic [PW-1:0]   tp_dec;
  ras_t            top;

  // explicit wrap compare keeps non-power-of-2 depths correct
  assign tp_inc = (tp_q == TP_MAX) ? '0 : tp_q + 1'b1;
  assign tp_dec = (tp_q == '0) ? TP_MAX : tp_q - 1'b1;

  always_comb begin
    top = '0;
    if (occ_q != '0) begin
      top.valid = valid_q[tp_q];
      top.ra    = ra_q[tp_q];
    end
  end

  assign data_o      = top;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i] <= 1'b0;
        ra_q[i]    <= '0;
      end
      tp_q  <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      priority case (1'b1)
        flush_bp_i: begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            valid_q[i] <= 1'b0;
          end
          tp_q  <= '0;
          occ_q <= '0;
        end
        (push_i && pop_i): begin
          valid_q[tp_q] <= 1'b1;
          ra_q[tp_q]    <= data_i;
          if (occ_q == '0) occ_q <= OW'(1);
        end
        push_i: begin
          tp_q            <= tp_inc;
          valid_q[tp_inc] <= 1'b1;
          ra_q[tp_inc]    <= data_i;
          if (occ_q == OCC_FULL) ovf_q <= 1'b1;
          else occ_q <= occ_q + OW'(1);
        end
        pop_i: begin
          if (occ_q != '0) begin
            valid_q[tp_q] <= 1'b0;
            tp_q          <= tp_dec;
            occ_q         <= occ_q - OW'(1);
          end else begin
            udf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAS_PERF_CNT_EN
  if (1) begin : g_perf
    logic [31:0] ovf_cnt_q;
    logic [31:0] udf_cnt_q;

    // flush deliberately leaves these alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ovf_cnt_q <= '0;
        udf_cnt_q <= '0;
      end else begin
        if (ovf_q && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 32'd1;
        if (udf_q && (udf_cnt_q != '1)) udf_cnt_q <= udf_cnt_q + 32'd1;
      end
    end

    assign ovf_cnt_o = ovf_cnt_q;
    assign udf_cnt_o = udf_cnt_q;
  end
`endif

endmodule
